wave_sel_ctrl: RTL and testbench
================================

# wave_sel_ctrl

Front-panel sequencer for the AD9708 waveform path. Debounces two active-low push buttons and steps the waveform selector through sine, square and triangle, either manually or by automatic timed scan. On every change it drives a mute strobe around the switch so the DAC path can hold midscale instead of emitting a discontinuity. Sits between the board keys and the waveform-select mux that feeds the DAC data bus.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: stable-level cycles required to accept a key change (20 ms at 50 MHz); must be ≥2.
- AUTO_DWELL, 50_000_000: RUN cycles per waveform in auto-scan; must be ≥2.
- MUTE_CYCLES, 16: mute pulse width in cycles; must be ≥2.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_next_n  in  1  raw button, low = pressed; advances waveform.
- key_mode_n  in  1  raw button, low = pressed; toggles auto-scan.
- sel  out  3  one-hot-low mux select: 3'b110 sine, 3'b101 square, 3'b011 triangle.
- wave_idx  out  2  0 sine, 1 square, 2 triangle; 3 never driven.
- mute  out  1  high while switching; downstream holds 8'h80.
- auto_en  out  1  auto-scan active.

## Operation
- Debounce per key: 2-flop synchronizer; counter increments each cycle the synchronized level differs from the stable level, clears whenever they match; when it differs at count DEBOUNCE_CYCLES-1, stable updates and the counter clears. One-cycle press pulse registered on a stable 1→0 transition; release produces no pulse. Stable resets to 1.
- mode press: toggles auto_en, clears dwell counter. Accepted in any state.
- Advance request = next press pulse OR (auto_en AND state RUN AND dwell_cnt == AUTO_DWELL-1). Both sources in the same cycle cause one advance.
- FSM states: RUN, MUTE.
  - RUN: dwell_cnt increments when auto_en, otherwise holds at 0. Request → MUTE, mute←1, mute_cnt←0, dwell_cnt←0.
  - MUTE: mute_cnt increments; on the first MUTE cycle, sel/wave_idx advance (sine→square→triangle→sine). When mute_cnt == MUTE_CYCLES-1 → RUN, mute←0. Requests arriving in MUTE are dropped; no queueing. dwell_cnt is held at 0.
- Mode and next presses in the same cycle: both take effect (toggle and advance).
- Reset, including mid-MUTE: sel=3'b110, wave_idx=0, mute=0, auto_en=0, state RUN, all counters 0, debounce stable=1, pulses 0.

## Timing
- Key latency: raw level first sampled low at edge 0 → press pulse high after edge 1+DEBOUNCE_CYCLES, for one cycle.
- Request high before edge e → mute=1 after edge e; sel/wave_idx change after edge e+1 (sel is registered one cycle after mute rises, which covers the one-cycle mux latency); mute=0 after edge e+MUTE_CYCLES.
- Auto-scan period = AUTO_DWELL + MUTE_CYCLES cycles per waveform.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- wave_pkg: SEL_SINE/SEL_SQUARE/SEL_TRI codes, wave index constants, FSM state encoding. Shared with the select mux and the wave generators.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, key_n, press), instantiated twice.
- Top level holds the FSM, the dwell/mute counters and the sel decode.

## Test plan
Parameters: DEBOUNCE_CYCLES=4, AUTO_DWELL=20, MUTE_CYCLES=4.
- Reset release with keys high → sel=110, wave_idx=0, mute=0, auto_en=0; no output change for 100 cycles.
- key_next_n held low 10 cycles from edge 0 → pulse after edge 5; mute high during edges 6–9; sel=101 from edge 7. Three further presses → 011, 110, 101.
- key_next_n bouncing (low 3, high 1, low 3, high 1 cycles) then high → no pulse, sel unchanged. Same bounce then held low → exactly one advance.
- Mode press → auto_en=1; sel advances every 24 cycles, sine→square→triangle→sine. Second mode press → auto_en=0; no further advance.
- Auto expiry coincides with a next pulse → single advance. Next press during MUTE → dropped, exactly one change. Mode and next pulses in the same cycle → auto_en toggles and sel advances.
- rst_n low in the middle of MUTE → all outputs return to reset values immediately (asynchronously); normal operation after release.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared waveform-select encodings, FSM states and index/select helpers.
// Pure definitions: no latency, no flow control.
package wave_pkg;

    localparam logic [2:0] SEL_SINE   = 3'b110;
    localparam logic [2:0] SEL_SQUARE = 3'b101;
    localparam logic [2:0] SEL_TRI    = 3'b011;

    localparam logic [1:0] IDX_SINE   = 2'd0;
    localparam logic [1:0] IDX_SQUARE = 2'd1;
    localparam logic [1:0] IDX_TRI    = 2'd2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MUTE = 1'b1
    } state_t;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        case (idx)
            IDX_SINE:   next_idx = IDX_SQUARE;
            IDX_SQUARE: next_idx = IDX_TRI;
            default:    next_idx = IDX_SINE;
        endcase
    endfunction

    function automatic logic [2:0] idx_to_sel(input logic [1:0] idx);
        case (idx)
            IDX_SQUARE: idx_to_sel = SEL_SQUARE;
            IDX_TRI:    idx_to_sel = SEL_TRI;
            default:    idx_to_sel = SEL_SINE;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low key; one-cycle press pulse on accepted 1->0.
// Latency 1+DEBOUNCE_CYCLES edges from first low sample to pulse; no backpressure.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level held long enough: accept it; only the falling edge is a press.
                stable <= sync2;
                cnt    <= '0;
                press  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_sel_ctrl.sv
// Front-panel waveform sequencer: manual/auto stepping with a mute strobe around each switch.
// mute rises 1 edge after a request, sel moves 1 edge later; requests during mute are dropped.
module wave_sel_ctrl
    import wave_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned AUTO_DWELL      = 50_000_000,
    parameter int unsigned MUTE_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_next_n,
    input  logic       key_mode_n,
    output logic [2:0] sel,
    output logic [1:0] wave_idx,
    output logic       mute,
    output logic       auto_en
);

    localparam int unsigned DW = (AUTO_DWELL > 2) ? $clog2(AUTO_DWELL) : 1;
    localparam int unsigned MW = (MUTE_CYCLES > 2) ? $clog2(MUTE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(AUTO_DWELL - 1);
    localparam logic [MW-1:0] MUTE_LAST  = MW'(MUTE_CYCLES - 1);

    logic next_press;
    logic mode_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_next_n),
        .press (next_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_mode_n),
        .press (mode_press)
    );

    state_t        state, state_nxt;
    logic [DW-1:0] dwell_cnt, dwell_nxt;
    logic [MW-1:0] mute_cnt, mute_cnt_nxt;
    logic [2:0]    sel_nxt;
    logic [1:0]    idx_nxt;
    logic          mute_nxt;
    logic          auto_nxt;
    logic          req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            dwell_cnt <= '0;
            mute_cnt  <= '0;
            sel       <= SEL_SINE;
            wave_idx  <= IDX_SINE;
            mute      <= 1'b0;
            auto_en   <= 1'b0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_nxt;
            mute_cnt  <= mute_cnt_nxt;
            sel       <= sel_nxt;
            wave_idx  <= idx_nxt;
            mute      <= mute_nxt;
            auto_en   <= auto_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        dwell_nxt    = dwell_cnt;
        mute_cnt_nxt = mute_cnt;
        sel_nxt      = sel;
        idx_nxt      = wave_idx;
        mute_nxt     = mute;
        auto_nxt     = auto_en ^ mode_press;
        // A simultaneous key press and dwell expiry collapse into a single request.
        req          = next_press | (auto_en & (dwell_cnt == DWELL_LAST));

        case (state)
            ST_RUN: begin
                if (req) begin
                    state_nxt    = ST_MUTE;
                    mute_nxt     = 1'b1;
                    mute_cnt_nxt = '0;
                    dwell_nxt    = '0;
                end else if (mode_press || !auto_en) begin
                    dwell_nxt = '0;
                end else begin
                    dwell_nxt = dwell_cnt + 1'b1;
                end
            end
            ST_MUTE: begin
                dwell_nxt    = '0;
                mute_cnt_nxt = mute_cnt + 1'b1;
                // Switch one cycle after mute rises so the mux latency is covered.
                if (mute_cnt == '0) begin
                    idx_nxt = next_idx(wave_idx);
                    sel_nxt = idx_to_sel(idx_nxt);
                end
                if (mute_cnt == MUTE_LAST) begin
                    state_nxt    = ST_RUN;
                    mute_nxt     = 1'b0;
                    mute_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_wave_sel_ctrl.sv
// Randomized and directed bench for wave_sel_ctrl against a window/countdown reference model.
module tb_wave_sel_ctrl;

    localparam int D = 4;
    localparam int A = 20;
    localparam int M = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_next_n;
    logic       key_mode_n;
    logic [2:0] sel;
    logic [1:0] wave_idx;
    logic       mute;
    logic       auto_en;

    int n_cmp = 0;
    int n_bad = 0;

    wave_sel_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .AUTO_DWELL      (A),
        .MUTE_CYCLES     (M)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_next_n (key_next_n),
        .key_mode_n (key_mode_n),
        .sel        (sel),
        .wave_idx   (wave_idx),
        .mute       (mute),
        .auto_en    (auto_en)
    );

    always #5 clk = ~clk;

    // Reference model: key accepted when its raw level was sampled D times in a row
    // (two edges back through the synchronizer) against the accepted level.
    bit       hist [2][D+2];
    bit       acc  [2];
    bit       pulse[2];
    int       m_left;
    int       m_idx;
    bit       m_auto;
    int       m_dwell;
    bit [2:0] sel_tab [3] = '{3'b110, 3'b101, 3'b011};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < D + 2; j++) hist[k][j] = 1'b1;
            acc[k]   = 1'b1;
            pulse[k] = 1'b0;
        end
        m_left  = 0;
        m_idx   = 0;
        m_auto  = 1'b0;
        m_dwell = 0;
    endtask

    task automatic model_step();
        bit busy;
        bit req;
        bit all_diff;
        busy = (m_left > 0);
        req  = pulse[0] || (m_auto && m_dwell == A - 1);
        if (busy) begin
            if (m_left == M) m_idx = (m_idx + 1) % 3;
            m_left--;
            m_dwell = 0;
        end else if (req) begin
            m_left  = M;
            m_dwell = 0;
        end else if (pulse[1] || !m_auto) begin
            m_dwell = 0;
        end else begin
            m_dwell++;
        end
        if (pulse[1]) m_auto = !m_auto;

        for (int k = 0; k < 2; k++) begin
            for (int j = D + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = (k == 0) ? key_next_n : key_mode_n;
            all_diff = 1'b1;
            for (int j = 2; j < D + 2; j++) if (hist[k][j] == acc[k]) all_diff = 1'b0;
            pulse[k] = 1'b0;
            if (all_diff) begin
                acc[k]   = !acc[k];
                pulse[k] = !acc[k];
            end
        end
    endtask

    task automatic check_outputs();
        chk("sel",      {5'd0, sel},      {5'd0, sel_tab[m_idx]});
        chk("wave_idx", {6'd0, wave_idx}, 8'(m_idx));
        chk("mute",     {7'd0, mute},     {7'd0, (m_left > 0)});
        chk("auto_en",  {7'd0, auto_en},  {7'd0, m_auto});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input bit use_next, input bit use_mode, input int len);
        if (use_next) key_next_n = 1'b0;
        if (use_mode) key_mode_n = 1'b0;
        ticks(len);
        key_next_n = 1'b1;
        key_mode_n = 1'b1;
        ticks(D + 4);
    endtask

    task automatic bounce();
        key_next_n = 1'b0; ticks(3);
        key_next_n = 1'b1; ticks(1);
        key_next_n = 1'b0; ticks(3);
        key_next_n = 1'b1; ticks(1);
    endtask

    initial begin
        int waited;
        rst_n      = 1'b0;
        key_next_n = 1'b1;
        key_mode_n = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        ticks(100);

        press(1'b1, 1'b0, 10);
        chk("first_adv", {5'd0, sel}, 8'h05);
        ticks(6);
        press(1'b1, 1'b0, 10); ticks(4);
        press(1'b1, 1'b0, 10); ticks(4);
        press(1'b1, 1'b0, 10); ticks(4);
        chk("after_four", {5'd0, sel}, 8'h05);

        bounce();
        ticks(12);
        chk("bounce_hold", {5'd0, sel}, 8'h05);
        bounce();
        key_next_n = 1'b0;
        ticks(10);
        key_next_n = 1'b1;
        ticks(12);
        chk("bounce_then_low", {5'd0, sel}, 8'h03);

        press(1'b0, 1'b1, 6);
        ticks(110);
        press(1'b0, 1'b1, 6);
        ticks(60);

        // Line the next-key pulse up with the auto-scan expiry.
        press(1'b0, 1'b1, 6);
        waited = 0;
        while (!(m_left == 0 && m_dwell == A - 3 - D) && waited < 200) begin
            tick();
            waited++;
        end
        chk("align_timeout", 8'(waited < 200), 8'd1);
        press(1'b1, 1'b0, 8);
        ticks(40);
        press(1'b0, 1'b1, 6);

        press(1'b1, 1'b1, 6);
        ticks(30);

        for (int ev = 0; ev < 150; ev++) begin
            int kind;
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: press(1'b1, 1'b0, $urandom_range(D + 1, 12));
                2:    press(1'b0, 1'b1, $urandom_range(D + 1, 8));
                3:    press(1'b1, 1'b1, $urandom_range(D + 1, 8));
                4:    bounce();
                default: ;
            endcase
            ticks($urandom_range(0, 30));
        end

        // Reset in the middle of a mute window.
        press(1'b1, 1'b0, 6);
        waited = 0;
        while (m_left != 2 && waited < 100) begin
            tick();
            waited++;
        end
        chk("mute_timeout", 8'(waited < 100), 8'd1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_sel",  {5'd0, sel},      8'h06);
        chk("arst_idx",  {6'd0, wave_idx}, 8'h00);
        chk("arst_mute", {7'd0, mute},     8'h00);
        chk("arst_auto", {7'd0, auto_en},  8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        press(1'b1, 1'b0, 10);
        ticks(10);
        chk("post_reset_adv", {5'd0, sel}, 8'h05);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
